// File: rtl/int_flag_ctrl.sv
// Interrupt controller feeding the C/Z flag register: edge-detects and prioritises IRQs,
// takes them at instruction boundaries, and replays the saved flags on RETI.
module int_flag_ctrl #(
    parameter int              N_IRQ      = 4,
    parameter int              PC_W       = 8,
    parameter logic [PC_W-1:0] VEC_BASE   = 'h10,
    parameter int              VEC_STRIDE = 4
) (
    input  logic             clkg,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic             mask_we_i,
    input  logic [N_IRQ-1:0] mask_d_i,
    input  logic             ie_i,
    input  logic             boundary_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic             c_i,
    input  logic             z_i,
    input  logic             reti_i,
    output logic             int_take_o,
    output logic [PC_W-1:0]  vector_o,
    output logic             in_isr_o,
    output logic             ret_valid_o,
    output logic [PC_W-1:0]  ret_pc_o,
    output logic             iwe_o,
    output logic             intc_o,
    output logic             intz_o,
    output logic [N_IRQ-1:0] pending_o
);
    localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic [1:0] {IDLE, TAKE, ISR, RESTORE} state_t;

    state_t           state_q, state_d;
    logic [N_IRQ-1:0] irq_q, irq_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [PC_W-1:0]  ret_pc_q, ret_pc_d;
    logic             sc_q, sc_d;
    logic             sz_q, sz_d;

    logic [N_IRQ-1:0] edge_det;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] clr_mask;
    logic [ID_W-1:0]  sel_id;
    logic             take_now;

    assign edge_det = irq_i & ~irq_q;
    assign eligible = pending_q & mask_q;
    assign take_now = (state_q == IDLE) && boundary_i && ie_i && (|eligible);

    // Scan from the top down so the last hit, i.e. the lowest index, wins.
    always_comb begin
        sel_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        ret_pc_d = ret_pc_q;
        sc_d     = sc_q;
        sz_d     = sz_q;
        clr_mask = '0;
        irq_d    = irq_i;
        mask_d   = mask_we_i ? mask_d_i : mask_q;
        case (state_q)
            IDLE: begin
                if (take_now) begin
                    state_d  = TAKE;
                    id_d     = sel_id;
                    ret_pc_d = pc_i;
                    sc_d     = c_i;
                    sz_d     = z_i;
                    clr_mask = N_IRQ'(1) << sel_id;
                end
            end
            TAKE:    state_d = ISR;
            ISR:     if (reti_i) state_d = RESTORE;
            RESTORE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A fresh edge on the bit being cleared re-pends it.
        pending_d = (pending_q & ~clr_mask) | edge_det;
    end

    always_ff @(posedge clkg or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            irq_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            id_q      <= '0;
            ret_pc_q  <= '0;
            sc_q      <= 1'b0;
            sz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            id_q      <= id_d;
            ret_pc_q  <= ret_pc_d;
            sc_q      <= sc_d;
            sz_q      <= sz_d;
        end
    end

    assign int_take_o  = (state_q == TAKE);
    assign vector_o    = VEC_BASE + PC_W'(id_q) * PC_W'(VEC_STRIDE);
    assign in_isr_o    = (state_q != IDLE);
    assign ret_valid_o = (state_q == RESTORE);
    assign iwe_o       = (state_q == RESTORE);
    assign ret_pc_o    = ret_pc_q;
    assign intc_o      = sc_q;
    assign intz_o      = sz_q;
    assign pending_o   = pending_q;

endmodule

// File: tb/tb_int_flag_ctrl.sv
// Bench for int_flag_ctrl: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a behavioural model of the controller.
module tb_int_flag_ctrl;
    logic       clkg, rst;
    logic [3:0] irq_i, mask_d_i;
    logic       mask_we_i, ie_i, boundary_i, c_i, z_i, reti_i;
    logic [7:0] pc_i;
    logic       int_take_o, in_isr_o, ret_valid_o, iwe_o, intc_o, intz_o;
    logic [7:0] vector_o, ret_pc_o;
    logic [3:0] pending_o;

    int n_cmp = 0;
    int n_fail = 0;

    int_flag_ctrl dut (
        .clkg(clkg), .rst(rst), .irq_i(irq_i), .mask_we_i(mask_we_i), .mask_d_i(mask_d_i),
        .ie_i(ie_i), .boundary_i(boundary_i), .pc_i(pc_i), .c_i(c_i), .z_i(z_i),
        .reti_i(reti_i), .int_take_o(int_take_o), .vector_o(vector_o), .in_isr_o(in_isr_o),
        .ret_valid_o(ret_valid_o), .ret_pc_o(ret_pc_o), .iwe_o(iwe_o), .intc_o(intc_o),
        .intz_o(intz_o), .pending_o(pending_o)
    );

    initial begin
        clkg = 1'b0;
        forever #5 clkg = ~clkg;
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: "busy" phases as plain flags, pending as a bit set.
    bit [3:0] m_prev, m_pend, m_mask;
    bit       m_take, m_serv, m_rest, m_c, m_z;
    bit [7:0] m_pc;
    int       m_id;

    always @(posedge clkg or posedge rst) begin
        if (rst) begin
            m_prev = 0; m_pend = 0; m_mask = 0; m_take = 0; m_serv = 0; m_rest = 0;
            m_c = 0; m_z = 0; m_pc = 0; m_id = 0;
        end else begin : upd
            bit [3:0] edges, elig;
            bit       go;
            int       sel;
            edges = irq_i & ~m_prev;
            elig  = m_pend & m_mask;
            go    = !(m_take || m_serv || m_rest) && boundary_i && ie_i && (elig != 0);
            if (go) begin
                sel = 0;
                while (!elig[sel]) sel++;
                m_id = sel; m_pc = pc_i; m_c = c_i; m_z = z_i;
                m_pend[sel] = 1'b0;
            end
            m_pend = m_pend | edges;
            if (mask_we_i) m_mask = mask_d_i;
            m_prev = irq_i;
            m_rest = m_serv && reti_i;
            m_serv = m_take || (m_serv && !reti_i);
            m_take = go;
        end
    end

    always @(negedge clkg) begin
        cmp("int_take", 32'(int_take_o), 32'(m_take));
        cmp("in_isr", 32'(in_isr_o), 32'(m_take | m_serv | m_rest));
        cmp("iwe", 32'(iwe_o), 32'(m_rest));
        cmp("ret_valid", 32'(ret_valid_o), 32'(m_rest));
        cmp("ret_pc", 32'(ret_pc_o), 32'(m_pc));
        cmp("intc", 32'(intc_o), 32'(m_c));
        cmp("intz", 32'(intz_o), 32'(m_z));
        cmp("pending", 32'(pending_o), 32'(m_pend));
        if (m_take) cmp("vector", 32'(vector_o), 32'h10 + 32'(m_id) * 4);
    end

    task automatic tick();
        @(negedge clkg);
        #1;
    endtask

    task automatic finish_isr();
        reti_i = 1'b1; tick();
        reti_i = 1'b0; tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; irq_i = 0; mask_d_i = 0; mask_we_i = 0; ie_i = 0; boundary_i = 0;
        pc_i = 0; c_i = 0; z_i = 0; reti_i = 0;
        tick(); tick();
        cmp("rst_vector", 32'(vector_o), 32'h10);
        cmp("rst_outs", {26'd0, int_take_o, in_isr_o, iwe_o, ret_valid_o, intc_o, intz_o}, 0);
        rst = 1'b0;

        // Single IRQ 0: take, then RETI replays flags
        mask_we_i = 1; mask_d_i = 4'b0001; ie_i = 1; tick();
        mask_we_i = 0; irq_i = 4'b0001; tick();
        cmp("pend_set", 32'(pending_o), 32'h1);
        irq_i = 0; boundary_i = 1; pc_i = 8'h3A; c_i = 1; z_i = 0; tick();
        cmp("take0", 32'(int_take_o), 1);
        cmp("vec0", 32'(vector_o), 32'h10);
        cmp("pend_clr", 32'(pending_o[0]), 0);
        cmp("isr0", 32'(in_isr_o), 1);
        boundary_i = 0; c_i = 0; tick();
        reti_i = 1; tick();
        cmp("iwe", 32'(iwe_o), 1);
        cmp("intc", 32'(intc_o), 1);
        cmp("intz", 32'(intz_o), 0);
        cmp("ret_valid", 32'(ret_valid_o), 1);
        cmp("ret_pc", 32'(ret_pc_o), 32'h3A);
        reti_i = 0; tick();
        cmp("idle_isr", 32'(in_isr_o), 0);

        // Simultaneous IRQ 1 and 3: lowest first
        mask_we_i = 1; mask_d_i = 4'b1111; tick();
        mask_we_i = 0; irq_i = 4'b1010; tick();
        irq_i = 0; boundary_i = 1; tick();
        cmp("vec1", 32'(vector_o), 32'h14);
        cmp("pend_left", 32'(pending_o), 32'h8);
        boundary_i = 0; tick();
        reti_i = 1; tick();
        reti_i = 0; boundary_i = 1; tick();
        cmp("restore_no_take", 32'(int_take_o), 0);
        tick();
        cmp("take3", 32'(int_take_o), 1);
        cmp("vec3", 32'(vector_o), 32'h1C);
        boundary_i = 0; tick();
        finish_isr();

        // IRQ 2 arriving during service only pends
        irq_i = 4'b0001; tick();
        irq_i = 0; boundary_i = 1; tick();
        irq_i = 4'b0100; tick();
        irq_i = 0;
        cmp("isr_pend2", 32'(pending_o), 32'h4);
        tick();
        cmp("no_nest", 32'(int_take_o), 0);
        reti_i = 1; tick();
        reti_i = 0; tick();
        cmp("post_restore", 32'(int_take_o), 0);
        tick();
        cmp("take2", 32'(int_take_o), 1);
        cmp("vec2", 32'(vector_o), 32'h18);
        boundary_i = 0; tick();
        finish_isr();

        // ie low holds pending
        ie_i = 0; irq_i = 4'b0010; tick();
        irq_i = 0; boundary_i = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            cmp("ie_off", 32'(int_take_o), 0);
        end
        ie_i = 1; tick();
        cmp("ie_on_vec", 32'(vector_o), 32'h14);
        boundary_i = 0; tick();
        finish_isr();

        // Masked pend; mask write on the decision cycle uses the old mask
        mask_we_i = 1; mask_d_i = 4'b1101; tick();
        mask_we_i = 0; irq_i = 4'b0010; tick();
        irq_i = 0; boundary_i = 1; tick(); tick();
        cmp("masked", 32'(int_take_o), 0);
        mask_we_i = 1; mask_d_i = 4'b1111; tick();
        cmp("old_mask", 32'(int_take_o), 0);
        mask_we_i = 0; tick();
        cmp("unmask_take", 32'(int_take_o), 1);
        boundary_i = 0; tick();
        finish_isr();

        // Reset in the middle of service
        irq_i = 4'b0001; tick();
        irq_i = 0; boundary_i = 1; pc_i = 8'h55; c_i = 1; z_i = 1; tick();
        boundary_i = 0; tick();
        cmp("pre_rst_c", 32'(intc_o), 1);
        rst = 1; #1;
        cmp("rst_isr", 32'(in_isr_o), 0);
        cmp("rst_outs2", {24'd0, ret_pc_o}, 0);
        cmp("rst_flags", {30'd0, intc_o, intz_o}, 0);
        tick();
        rst = 0; reti_i = 1; tick();
        cmp("rst_reti_iwe", 32'(iwe_o), 0);
        reti_i = 0;

        // Random phase
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0) irq_i = 4'($urandom_range(0, 15));
            mask_we_i  = ($urandom_range(0, 15) == 0);
            mask_d_i   = 4'($urandom_range(0, 15));
            ie_i       = ($urandom_range(0, 7) != 0);
            boundary_i = ($urandom_range(0, 1) == 1);
            reti_i     = ($urandom_range(0, 3) == 0);
            pc_i       = 8'($urandom_range(0, 255));
            c_i        = 1'($urandom_range(0, 1));
            z_i        = 1'($urandom_range(0, 1));
            rst        = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/int_flag_ctrl.md
Name: int_flag_ctrl

Overview:
- Interrupt controller directly upstream of the C/Z flag register. Feeds it `iwe`, `intc_i` and `intz_i`.
- Detects and prioritises IRQ edges, takes an interrupt at an instruction boundary, and saves the return PC and the C/Z flags.
- On RETI, replays the saved flags into the flag register through a one-cycle interrupt-write pulse.

Parameters:
- N_IRQ, 4, number of interrupt request lines.
- PC_W, 8, program counter width.
- VEC_BASE, 8'h10, address of the vector for IRQ 0.
- VEC_STRIDE, 4, address spacing between vectors.

Ports:
- clkg  in  1  gated CPU clock.
- rst  in  1  reset, asynchronous, active-high.
- irq_i  in  N_IRQ  request lines, rising-edge sensitive.
- mask_we_i  in  1  mask register write strobe.
- mask_d_i  in  N_IRQ  mask write data; 1 = enabled.
- ie_i  in  1  global interrupt enable from the core.
- boundary_i  in  1  core is at an instruction boundary (fetch slot).
- pc_i  in  PC_W  PC of the next instruction to execute.
- c_i  in  1  current carry flag (flag register output).
- z_i  in  1  current zero flag (flag register output).
- reti_i  in  1  one-cycle RETI strobe from decode.
- int_take_o  out  1  one-cycle pulse: core jumps to vector_o.
- vector_o  out  PC_W  ISR entry address.
- in_isr_o  out  1  interrupt service in progress.
- ret_valid_o  out  1  one-cycle pulse: core loads ret_pc_o into PC.
- ret_pc_o  out  PC_W  saved return PC.
- iwe_o  out  1  interrupt flag write enable to the flag register.
- intc_o  out  1  saved carry flag.
- intz_o  out  1  saved zero flag.
- pending_o  out  N_IRQ  pending register (debug/readback).

Behaviour:
- Reset (async, any state): state=IDLE; irq_q, pending, mask, saved PC, saved flags and id all 0. All outputs are 0; vector_o=VEC_BASE.
- Edge detect: irq_q <= irq_i each clkg. Edge = irq_i & ~irq_q. The pending bit sets on the clock where the edge is seen and is visible the next cycle.
- Mask: mask <= mask_d_i when mask_we_i. Masked IRQs still pend but are never taken.
- Eligible = pending & mask. Priority is lowest index first.

FSM states are IDLE, TAKE, ISR, RESTORE.
- IDLE: if boundary_i & ie_i & |eligible, go to TAKE. On that edge:
  - latch id;
  - save ret PC <= pc_i, saved C <= c_i, saved Z <= z_i;
  - clear pending[id].
- TAKE (exactly 1 cycle): int_take_o=1, vector_o = VEC_BASE + id*VEC_STRIDE, truncated to PC_W bits. Then go to ISR.
- ISR: in_isr_o=1. No nesting: new edges only pend. reti_i goes to RESTORE.
- RESTORE (exactly 1 cycle), then IDLE:
  - iwe_o=1, intc_o=saved C, intz_o=saved Z;
  - ret_valid_o=1, ret_pc_o = saved PC;
  - in_isr_o stays 1 during this cycle.
- in_isr_o=1 in TAKE, ISR and RESTORE.
- Latency:
  - boundary to int_take_o: 1 cycle.
  - reti_i to iwe_o/ret_valid_o: 1 cycle.
  - edge to earliest take: 2 cycles.
- Boundary cases:
  - Edge on the same bit in the cycle its pending bit is cleared: set wins, so the IRQ re-pends.
  - reti_i in IDLE or TAKE: ignored, no iwe_o.
  - boundary_i outside IDLE: ignored.
  - ie_i=0: pending held, nothing taken.
  - Level held high: only one pend; a new pend needs a low-then-high transition.
  - mask_we_i in the same cycle as the take decision: the decision uses the old mask.
  - Reset mid-ISR or mid-RESTORE: iwe_o drops immediately and saved state is lost.
- Saved flags and PC hold their value from the take until the next take. ret_pc_o, intc_o and intz_o show the saved values in all states.

Test Plan:
- Reset, mask=4'b0001, ie=1, pulse irq_i[0], boundary_i=1 with pc_i=8'h3A, c_i=1, z_i=0 -> int_take_o pulse with vector_o=8'h10; pending_o[0]=0; in_isr_o=1.
- From ISR, pulse reti_i -> next cycle iwe_o=1, intc_o=1, intz_o=0, ret_valid_o=1, ret_pc_o=8'h3A; then IDLE, in_isr_o=0.
- mask=4'b1111, edges on irq[1] and irq[3] in the same cycle -> first take vector 8'h14, after RETI the next take vector 8'h1C.
- irq[2] edge while in ISR -> no int_take_o until after RESTORE; pending_o[2]=1 throughout, taken at the next boundary.
- ie=0 or mask bit 0 with a pending IRQ, boundary held high -> no take. Raising ie or mask -> take on the next boundary.
- Assert rst in ISR, then pulse reti_i -> no iwe_o, all outputs 0.
